// File: rtl/run_monitor.sv
// Job-issue and progress monitor: launches one job per reset session, counts
// datapath beats while the controller is busy, and reports done or beat-gap timeout.
module run_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             beat_valid,
  input  logic             busy,
  output logic             start,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             sts_done,
  output logic             sts_fail
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_COUNT,
    S_DONE_HOLD,
    S_ERR_HOLD,
    S_FINISHED,
    S_FAILED
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   w_len_nxt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [IDLE_W-1:0]  w_idle_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   w_beat_nxt;
  logic               r_cmd_ready;
  logic               r_start;
  logic               r_done;
  logic               r_error;
  logic               r_sts_done;
  logic               r_sts_fail;

  // Next-state and counter updates; the idle counter stops at IDLE_MAX because every state leaves there
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idle_nxt  = r_idle_cnt;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_len_nxt = cmd_len;
          if (cmd_len != '0) begin
            w_state_nxt = S_ARM;
          end
        end
      end
      S_ARM: begin
        w_idle_nxt  = '0;
        w_beat_nxt  = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (busy) begin
          w_idle_nxt  = '0;
          w_state_nxt = S_COUNT;
        end else if (r_idle_cnt == IDLE_MAX) begin
          w_state_nxt = S_FAILED;
        end else begin
          w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end
      S_COUNT: begin
        if (!busy) begin
          w_state_nxt = S_FAILED;
        end else if (beat_valid) begin
          // A final beat on the expiry cycle still completes the job
          w_beat_nxt = r_beat_cnt + CNT_W'(1);
          w_idle_nxt = '0;
          if (w_beat_nxt == r_len) begin
            w_state_nxt = S_DONE_HOLD;
          end
        end else if (r_idle_cnt == IDLE_MAX) begin
          w_state_nxt = S_ERR_HOLD;
        end else begin
          w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end
      S_DONE_HOLD: begin
        if (!busy) begin
          w_state_nxt = S_FINISHED;
        end
      end
      S_ERR_HOLD: begin
        if (!busy) begin
          w_state_nxt = S_FAILED;
        end
      end
      S_FINISHED: w_state_nxt = S_FINISHED;
      S_FAILED:   w_state_nxt = S_FAILED;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // State register; outputs are registered decodes of the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idle_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_cmd_ready <= 1'b1;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_sts_done  <= 1'b0;
      r_sts_fail  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_start     <= (w_state_nxt == S_ARM);
      r_done      <= (w_state_nxt == S_DONE_HOLD);
      r_error     <= (w_state_nxt == S_ERR_HOLD);
      r_sts_done  <= r_sts_done | (w_state_nxt == S_FINISHED);
      r_sts_fail  <= r_sts_fail | (w_state_nxt == S_FAILED);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign start     = r_start;
  assign done      = r_done;
  assign error     = r_error;
  assign beat_cnt  = r_beat_cnt;
  assign sts_done  = r_sts_done;
  assign sts_fail  = r_sts_fail;

endmodule

// File: tb/tb_run_monitor.sv
// Randomized bench for run_monitor with a job-level behavioural model and a
// simple controller model that raises busy on start and drops it on done/error.
module tb_run_monitor;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_COUNT = 3;
  localparam int P_DHOLD = 4;
  localparam int P_EHOLD = 5;
  localparam int P_FIN   = 6;
  localparam int P_FAIL  = 7;

  localparam int CTL_NORMAL = 0;
  localparam int CTL_NEVER  = 1;
  localparam int CTL_DROP   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             beat_valid = 1'b0;
  logic             busy = 1'b0;
  logic             start;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] beat_cnt;
  logic             sts_done;
  logic             sts_fail;

  int n_total = 0;
  int n_bad   = 0;

  int m_phase, m_len, m_beats, m_quiet, m_arms;
  int cmds[$];
  int gaps[$];
  int ctl_mode, drop_after, count_cycles, dut_starts;
  logic ctl_busy, seen_start, seen_done, seen_err;

  always #5 clk = ~clk;

  run_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .beat_valid (beat_valid),
    .busy       (busy),
    .start      (start),
    .done       (done),
    .error      (error),
    .beat_cnt   (beat_cnt),
    .sts_done   (sts_done),
    .sts_fail   (sts_fail)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == P_IDLE));
    chk("start",     32'(start),     32'(m_phase == P_ARM));
    chk("done",      32'(done),      32'(m_phase == P_DHOLD));
    chk("error",     32'(error),     32'(m_phase == P_EHOLD));
    chk("beat_cnt",  32'(beat_cnt),  32'(m_beats));
    chk("sts_done",  32'(sts_done),  32'(m_phase == P_FIN));
    chk("sts_fail",  32'(sts_fail),  32'(m_phase == P_FAIL));
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_len   = 0;
    m_beats = 0;
    m_quiet = 0;
    m_arms  = 0;
  endtask

  // Job-level rules: quiet counts consecutive unproductive cycles; TIMEOUT of them trips failure
  task automatic model_step(input logic cv, input int cl, input logic bv, input logic by);
    case (m_phase)
      P_IDLE: if (cv && cl != 0) begin
        m_len = cl;
        m_phase = P_ARM;
        m_arms++;
      end
      P_ARM: begin
        m_beats = 0;
        m_quiet = 0;
        m_phase = P_WAIT;
      end
      P_WAIT: if (by) begin
        m_quiet = 0;
        m_phase = P_COUNT;
      end else begin
        m_quiet++;
        if (m_quiet == int'(TIMEOUT)) m_phase = P_FAIL;
      end
      P_COUNT: if (!by) begin
        m_phase = P_FAIL;
      end else if (bv) begin
        m_beats++;
        m_quiet = 0;
        if (m_beats == m_len) m_phase = P_DHOLD;
      end else begin
        m_quiet++;
        if (m_quiet == int'(TIMEOUT)) m_phase = P_EHOLD;
      end
      P_DHOLD: if (!by) m_phase = P_FIN;
      P_EHOLD: if (!by) m_phase = P_FAIL;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    beat_valid = 1'b0;
    busy = 1'b0;
    ctl_busy = 1'b0;
    seen_start = 1'b0;
    seen_done = 1'b0;
    seen_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  task automatic run_session(input bit do_rst, input bit abort_mid);
    int term;
    bit aborted;
    if (do_rst) do_reset();
    dut_starts = 0;
    count_cycles = 0;
    term = 0;
    aborted = 0;
    for (int i = 0; i < 600 && term < 4; i++) begin
      @(negedge clk);
      check_outputs();
      if (start) dut_starts++;
      if (abort_mid && m_phase == P_COUNT && m_beats == 3) begin
        // Asynchronous clear between clock edges
        #2 reset = 1'b0;
        cmd_valid = 1'b0;
        beat_valid = 1'b0;
        busy = 1'b0;
        ctl_busy = 1'b0;
        seen_start = 1'b0;
        seen_done = 1'b0;
        seen_err = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        aborted = 1;
        break;
      end
      if (ctl_mode != CTL_NEVER) begin
        if (seen_start) ctl_busy = 1'b1;
        if (seen_done || seen_err) ctl_busy = 1'b0;
      end
      if (ctl_mode == CTL_DROP && m_phase == P_COUNT && count_cycles >= drop_after) ctl_busy = 1'b0;
      seen_start = start;
      seen_done = done;
      seen_err = error;
      busy = ctl_busy;
      if (m_phase == P_IDLE) begin
        cmd_valid = 1'b0;
        cmd_len = CNT_W'($urandom);
        if (cmds.size() > 0 && $urandom_range(0, 3) != 0) begin
          cmd_valid = 1'b1;
          cmd_len = CNT_W'(cmds.pop_front());
        end
      end else begin
        cmd_valid = 1'($urandom);
        cmd_len = CNT_W'($urandom);
      end
      if (m_phase == P_COUNT) begin
        beat_valid = 1'b0;
        if (gaps.size() > 0) begin
          if (m_quiet == gaps[0]) begin
            beat_valid = 1'b1;
            void'(gaps.pop_front());
          end
        end
        count_cycles++;
      end else begin
        beat_valid = 1'($urandom);
      end
      model_step(cmd_valid, int'(cmd_len), beat_valid, busy);
      if (m_phase >= P_FIN) term++;
    end
    if (!aborted) begin
      @(negedge clk);
      check_outputs();
      chk("terminal", 32'(sts_done | sts_fail), 32'(1));
      chk("start_cnt", 32'(dut_starts), 32'(m_arms));
    end
  endtask

  initial begin
    model_reset();
    ctl_busy = 1'b0;
    seen_start = 1'b0;
    seen_done = 1'b0;
    seen_err = 1'b0;
    drop_after = 0;

    ctl_mode = CTL_NORMAL;
    cmds = '{4};  gaps = '{0, 0, 0, 0};     run_session(1, 0);
    cmds = '{3};  gaps = '{15, 15, 15};     run_session(1, 0);
    cmds = '{5};  gaps = '{0, 0};           run_session(1, 0);
    cmds = '{2};  gaps = '{0, 15};          run_session(1, 0);

    ctl_mode = CTL_NEVER;
    cmds = '{0, 5}; gaps.delete();          run_session(1, 0);

    ctl_mode = CTL_DROP; drop_after = 6;
    cmds = '{6};  gaps = '{0, 1, 1, 1, 1, 1}; run_session(1, 0);

    ctl_mode = CTL_NORMAL;
    cmds = '{8};  gaps = '{0, 0, 0, 2, 2};  run_session(1, 1);
    cmds = '{1};  gaps = '{3};              run_session(0, 0);

    cmds = '{255}; gaps.delete();
    for (int k = 0; k < 255; k++) gaps.push_back(0);
    run_session(1, 0);

    for (int s = 0; s < 25; s++) begin
      int len;
      int r;
      len = int'($urandom_range(1, 12));
      cmds.delete();
      gaps.delete();
      if ($urandom_range(0, 3) == 0) cmds.push_back(0);
      cmds.push_back(len);
      for (int b = 0; b < len; b++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       gaps.push_back(int'($urandom_range(0, 3)));
        else if (r < 8)  gaps.push_back(int'($urandom_range(10, 15)));
        else if (r == 8) gaps.push_back(15);
        else             gaps.push_back(16);
      end
      r = int'($urandom_range(0, 9));
      if (r == 0) ctl_mode = CTL_NEVER;
      else if (r == 1) begin
        ctl_mode = CTL_DROP;
        drop_after = int'($urandom_range(0, 20));
      end else ctl_mode = CTL_NORMAL;
      run_session(1, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
